// File: rtl/btn_bounce_emulator.sv
// btn_bounce_emulator: turns a clean level request into a bouncy pushbutton
// waveform. A request toggles btn_out at LFSR-randomised intervals for a fixed
// bounce window, forces the requested level, holds it stable, then pulses done.
//
// Handshake: start is sampled only in IDLE and is otherwise ignored (no
// queuing); busy is high for the whole bounce+settle period; done is a single
// cycle pulse after the settle period (or right away if no change is needed).
module btn_bounce_emulator #(
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          SETTLE_CYCLES = 32,
    parameter int          MIN_GLITCH    = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       level,
    output logic       btn_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] edge_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // An all-zero seed would lock the LFSR, so fall back to the default.
    localparam logic [15:0] SEED      = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] BC_LAST   = 16'(BOUNCE_CYCLES - 1);
    // btn_out is registered, so the level seen in the last bounce cycle is
    // decided one cycle earlier.
    localparam logic [15:0] BC_FORCE  = 16'(BOUNCE_CYCLES - 2);
    // Latest window position at which a toggle may still happen so that the
    // resulting pulse lasts at least MIN_GLITCH cycles before the forced level.
    localparam logic [15:0] BC_TOGMAX = 16'(BOUNCE_CYCLES - 2 - MIN_GLITCH);
    localparam logic [15:0] SC_LAST   = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] MG        = 16'(MIN_GLITCH);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_lfsr;
    logic [15:0] r_win;
    logic [15:0] r_seg;
    logic        r_target;
    logic        r_btn;
    logic [7:0]  r_cnt;

    logic        w_accept;
    logic        w_btn_next;
    logic [15:0] w_seg_len;
    logic        w_fb;

    assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_seg_len = MG + {12'd0, r_lfsr[3:0]};
    assign w_accept  = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = (level != r_btn) ? S_BOUNCE : S_DONE;
            S_BOUNCE: if (r_win == BC_LAST) w_next = S_SETTLE;
            S_SETTLE: if (r_win == SC_LAST) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Next button level: segment-end toggles, then the forced final level.
    always_comb begin
        w_btn_next = r_btn;
        if (r_state == S_BOUNCE) begin
            if (r_win == BC_FORCE)
                w_btn_next = r_target;
            else if (r_win <= BC_TOGMAX && r_seg == 16'd1)
                w_btn_next = ~r_btn;
        end
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11).
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= SEED;
        else     r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    // Window/settle counter, segment counter, target and button registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win    <= '0;
            r_seg    <= '0;
            r_target <= 1'b0;
            r_btn    <= 1'b0;
        end else begin
            r_btn <= w_btn_next;
            case (r_state)
                S_IDLE: begin
                    r_win <= '0;
                    if (start) begin
                        r_target <= level;
                        r_seg    <= w_seg_len;
                    end
                end
                S_BOUNCE: begin
                    r_win <= (r_win == BC_LAST) ? 16'd0 : r_win + 16'd1;
                    r_seg <= (r_seg == 16'd1) ? w_seg_len : r_seg - 16'd1;
                end
                S_SETTLE: r_win <= r_win + 16'd1;
                default:  r_win <= '0;
            endcase
        end
    end

    // Transition counter: cleared on accept, saturates at 255, held otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if (w_btn_next != r_btn && r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
    end

    assign btn_out    = r_btn;
    assign busy       = (r_state == S_BOUNCE) || (r_state == S_SETTLE);
    assign done       = (r_state == S_DONE);
    assign edge_count = r_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_btn_bounce_emulator.sv
// Directed bench for btn_bounce_emulator with default parameters.
// Cycle N+k below means the sample taken 1 time unit after the k-th edge
// following the start edge N (i.e. the cycle after edge N+k-1).
module tb_btn_bounce_emulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       level;
  logic       btn_out;
  logic       busy;
  logic       done;
  logic [7:0] edge_count;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  btn_bounce_emulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .level      (level),
    .btn_out    (btn_out),
    .busy       (busy),
    .done       (done),
    .edge_count (edge_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // downstream debouncer + press toggle model fed by btn_out
  logic       db_state;
  logic [7:0] db_cnt;
  logic       tog;
  int         flips;

  always @(posedge clk) begin
    if (rst) begin
      db_state <= 1'b0;
      db_cnt   <= 8'd0;
      tog      <= 1'b0;
      flips    <= 0;
    end else if (btn_out != db_state) begin
      if (db_cnt == 8'd23) begin
        db_state <= btn_out;
        db_cnt   <= 8'd0;
        if (btn_out) begin
          tog   <= ~tog;
          flips <= flips + 1;
        end
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end else begin
      db_cnt <= 8'd0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    level = 1'b1;
    do_reset();
    start = 1'b0;
    total++;
    if (btn_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || edge_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: btn=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
               btn_out, busy, done, edge_count);
    end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      total++;
      if (btn_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || edge_count !== 8'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: btn=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                 i, btn_out, busy, done, edge_count);
      end
    end
  endtask

  task automatic test_no_change();
    @(negedge clk);
    start = 1'b1;
    level = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (done !== (k == 1) || busy !== 1'b0 || btn_out !== 1'b0 || edge_count !== 8'd0) begin
        bad++;
        $display("FAIL no_change k=%0d: done=%b busy=%b btn=%b cnt=%0d want done=%b busy=0 btn=0 cnt=0",
                 k, done, busy, btn_out, edge_count, (k == 1));
      end
      @(posedge clk); #1;
    end
  endtask

  // One full request towards lvl; btn_out must currently be ~lvl.
  task automatic test_request(input logic lvl);
    int   trans = 0;
    int   last_chg = -1;
    logic prev;
    prev = btn_out;
    @(negedge clk);
    start = 1'b1;
    level = lvl;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      total++;
      if (busy !== (k <= 96)) begin
        bad++;
        $display("FAIL req%0d_busy k=%0d: got %b want %b", lvl, k, busy, (k <= 96));
      end
      total++;
      if (done !== (k == 97)) begin
        bad++;
        $display("FAIL req%0d_done k=%0d: got %b want %b", lvl, k, done, (k == 97));
      end
      if (k >= 64) begin
        total++;
        if (btn_out !== lvl) begin
          bad++;
          $display("FAIL req%0d_level k=%0d: got %b want %b", lvl, k, btn_out, lvl);
        end
      end
      if (btn_out !== prev) begin
        trans++;
        if (last_chg > 0) begin
          total++;
          if (k - last_chg < 2) begin
            bad++;
            $display("FAIL req%0d_pulse k=%0d: width %0d want >=2", lvl, k, k - last_chg);
          end
        end
        last_chg = k;
        prev = btn_out;
      end
      @(posedge clk); #1;
    end
    total++;
    if (edge_count !== 8'(trans) || (trans % 2) != 1) begin
      bad++;
      $display("FAIL req%0d_edges: cnt=%0d observed=%0d want equal and odd", lvl, edge_count, trans);
    end
  endtask

  task automatic test_busy_drop();
    @(negedge clk);
    start = 1'b1;
    level = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 97 || k == 98) begin
        total++;
        if (done !== (k == 97) || btn_out !== 1'b1) begin
          bad++;
          $display("FAIL busy_drop k=%0d: done=%b btn=%b want done=%b btn=1",
                   k, done, btn_out, (k == 97));
        end
      end
      if (k == 10) begin
        start = 1'b1;
        level = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    start = 1'b1;
    level = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL mid_busy k=%0d: got %b want 1", k, busy);
      end
      if (k == 30) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    total++;
    if (btn_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || edge_count !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset: btn=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
               btn_out, busy, done, edge_count);
    end
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || btn_out !== 1'b0) begin
        bad++;
        $display("FAIL mid_after cyc=%0d: done=%b busy=%b btn=%b want 0 0 0",
                 i, done, busy, btn_out);
      end
    end
  endtask

  task automatic test_end_to_end();
    logic seq [4];
    int   exp_flips [4];
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0;
    exp_flips[0] = 1; exp_flips[1] = 1; exp_flips[2] = 2; exp_flips[3] = 2;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      bit seen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      level = seq[r];
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        if (done === 1'b1) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL e2e_timeout req=%0d: done not seen within 300 cycles", r);
      end
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (flips !== exp_flips[r] || btn_out !== seq[r]) begin
        bad++;
        $display("FAIL e2e_toggle req=%0d: flips=%0d btn=%b want flips=%0d btn=%b",
                 r, flips, btn_out, exp_flips[r], seq[r]);
      end
    end
    total++;
    if (tog !== 1'b0) begin
      bad++;
      $display("FAIL e2e_final: tog=%b want 0", tog);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    level = 1'b0;
    test_reset();
    test_no_change();
    test_request(1'b1);
    test_request(1'b0);
    test_busy_drop();
    test_request(1'b0);
    test_reset_mid();
    test_end_to_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_bounce_emulator.md
BTN_BOUNCE_EMULATOR -- requirements
Module: btn_bounce_emulator

Purpose: synthetic bouncing-button transmitter. Turns a clean level request into a bouncy pushbutton waveform that drives the debouncer/toggle input for on-board self-test.

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64, SHALL set the bounce-window length in clk cycles (min 16).
REQ-002 Parameter SETTLE_CYCLES, default 32, SHALL set the stable-hold length after the bounce window (min 1).
REQ-003 Parameter MIN_GLITCH, default 2, SHALL set the minimum bounce-segment length in cycles (min 1).
REQ-004 Parameter LFSR_SEED, default 16'hACE1, SHALL set the LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-005 clk  input  1  sole clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to move btn_out to level.
REQ-008 level  input  1  target button level, sampled with start.
REQ-009 btn_out  output  1  emulated raw button signal, registered.
REQ-010 busy  output  1  high while a request is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 edge_count  output  8  transitions emitted by the last request, saturating at 255.

Function
REQ-013 The FSM SHALL have the states IDLE, BOUNCE, SETTLE and DONE.
REQ-014 In IDLE, start=1 at edge N SHALL latch level as target, clear edge_count, and enter BOUNCE (target != btn_out) or DONE (target == btn_out).
REQ-015 The block SHALL ignore start whenever state != IDLE, with no queuing.
REQ-016 busy SHALL be 1 in BOUNCE and SETTLE and 0 in IDLE and DONE.
REQ-017 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle in every state.
REQ-018 BOUNCE SHALL last exactly BOUNCE_CYCLES cycles, counted by a window counter.
REQ-019 Within BOUNCE, btn_out SHALL toggle at the end of each segment, with segment length = MIN_GLITCH + lfsr[3:0] sampled at segment start.
REQ-020 A segment reaching the window end SHALL be truncated, with no toggle at truncation.
REQ-021 On the last BOUNCE cycle, btn_out SHALL be forced to target (a toggle only if it differs), so total transitions per request are always odd.
REQ-022 edge_count SHALL increment on every btn_out transition and saturate at 255.
REQ-023 SETTLE SHALL hold btn_out = target for exactly SETTLE_CYCLES cycles, then enter DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 Latency SHALL be: start at edge N gives done high in cycle N+1+BOUNCE_CYCLES+SETTLE_CYCLES (bounce path) or N+1 (no-change path).
REQ-026 btn_out SHALL NOT change in IDLE, SETTLE or DONE.
REQ-027 edge_count SHALL hold its value from DONE until the next accepted start.

Reset
REQ-028 rst=1 at any edge, including mid-BOUNCE or mid-SETTLE, SHALL produce on the next cycle: state=IDLE, btn_out=0, busy=0, done=0, edge_count=0, lfsr=seed, counters=0.
REQ-029 rst SHALL take priority over start in the same cycle.

Verification
REQ-030 Reset: assert rst 2 cycles, then release -> btn_out=0, busy=0, done=0, edge_count=0; no activity for 100 cycles with start=0.
REQ-031 Press (defaults): btn_out=0, start=1, level=1 at edge N -> busy=1 in N+1..N+96, done=1 only in cycle N+97, btn_out=1 throughout N+64..N+97, edge_count odd and >=1, every bounce pulse >=2 cycles wide.
REQ-032 No-change: btn_out=0, start=1, level=0 -> done=1 in cycle N+1, busy never 1, edge_count=0, btn_out stays 0.
REQ-033 Busy drop: start=1, level=0 issued at N+10 during a press -> ignored; press completes at N+97 with btn_out=1.
REQ-034 Reset mid-operation: rst=1 at N+30 during BOUNCE -> btn_out=0, busy=0 at N+31; done never pulses.
REQ-035 End-to-end: chain btn_out into the debounce/toggle path; 4 alternating press/release requests (start/level 1,0,1,0) -> downstream toggle output flips exactly twice, once per press.
